// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic phase controller: phase codes, lamp patterns, limits.
package traffic_pkg;

  typedef enum logic [1:0] {
    HW_PASS = 2'd0,
    HW_WARN = 2'd1,
    CR_PASS = 2'd2,
    CR_WARN = 2'd3
  } phase_t;

  localparam logic [3:0] LED_HW_PASS = 4'b0011;
  localparam logic [3:0] LED_HW_WARN = 4'b0110;
  localparam logic [3:0] LED_CR_PASS = 4'b1001;
  localparam logic [3:0] LED_CR_WARN = 4'b1100;

  localparam logic [7:0] T_PED_SHORT = 8'd10;
  localparam logic [7:0] REMAIN_MAX  = 8'd99;

  function automatic logic [3:0] led_of(phase_t p);
    logic [3:0] led;
    case (p)
      HW_PASS: led = LED_HW_PASS;
      HW_WARN: led = LED_HW_WARN;
      CR_PASS: led = LED_CR_PASS;
      default: led = LED_CR_WARN;
    endcase
    return led;
  endfunction

  // Widened add so a carry past 255 still saturates to REMAIN_MAX.
  function automatic logic [7:0] sat_add(logic [7:0] a, logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, REMAIN_MAX}) ? REMAIN_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Request inputs and phase/countdown outputs of the traffic phase controller.
interface traffic_phase_ctrl_if;
  import traffic_pkg::*;

  // Plain level signals, no valid/ready: requests are sampled every cycle and act on a
  // rising edge; outputs are registered and valid every cycle after reset.
  logic       ext_req;
  logic       ped_req;
  phase_t     phase;
  logic [7:0] remain;
  logic [3:0] LED;
  logic       phase_end;
  logic [2:0] ext_cnt;

  modport master (
    output ext_req, ped_req,
    input  phase, remain, LED, phase_end, ext_cnt
  );

  modport slave (
    input  ext_req, ped_req,
    output phase, remain, LED, phase_end, ext_cnt
  );

endinterface

// File: rtl/phase_tick_gen.sv
// Free-running divider: one-cycle tick_o every TICK_DIV clocks (counter wraps after TICK_DIV-1).
module phase_tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Four-phase highway/crossing sequencer with crossing extension and highway early end.
// Optional feature macro PED_REQ_EN: pedestrian request shortens HW_PASS once per phase.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned T_HW_PASS = 99,
  parameter int unsigned T_HW_WARN = 33,
  parameter int unsigned T_CR_PASS = 66,
  parameter int unsigned T_CR_WARN = 0,
  parameter int unsigned EXT_STEP  = 30,
  parameter int unsigned EXT_MAX   = 3
) (
  input  logic                Sys_CLK,
  input  logic                Sys_RST,
  traffic_phase_ctrl_if.slave tp
);

  localparam logic [7:0] D_HW_PASS = 8'(T_HW_PASS);
  localparam logic [7:0] D_HW_WARN = 8'(T_HW_WARN);
  localparam logic [7:0] D_CR_PASS = 8'(T_CR_PASS);
  localparam logic [7:0] D_CR_WARN = 8'(T_CR_WARN);
  localparam logic [7:0] D_STEP    = 8'(EXT_STEP);
  localparam logic [2:0] D_EXT_MAX = 3'(EXT_MAX);

  function automatic logic [7:0] dur_of(phase_t p);
    logic [7:0] d;
    case (p)
      HW_PASS: d = D_HW_PASS;
      HW_WARN: d = D_HW_WARN;
      CR_PASS: d = D_CR_PASS;
      default: d = D_CR_WARN;
    endcase
    return d;
  endfunction

  function automatic phase_t next_of(phase_t p);
    phase_t n;
    case (p)
      CR_PASS: n = HW_PASS;
      HW_PASS: n = HW_WARN;
      HW_WARN: n = (T_CR_WARN == 0) ? CR_PASS : CR_WARN;
      default: n = CR_PASS;
    endcase
    return n;
  endfunction

  phase_t     phase_q;
  logic [7:0] remain_q;
  logic [3:0] led_q;
  logic       phase_end_q;
  logic [2:0] ext_cnt_q;
  logic       ext_prev_q;

  logic       tick;
  logic       ext_edge;
  logic       terminal;
  logic       early_ok;
  logic       ext_ok;
  logic       ped_apply;
  phase_t     phase_d;
  logic [7:0] remain_base_d;
  logic [7:0] remain_ext_d;

  phase_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (Sys_CLK),
    .rst_i  (Sys_RST),
    .tick_o (tick)
  );

  assign ext_edge      = tp.ext_req & ~ext_prev_q;
  assign terminal      = tick & (remain_q == 8'd1);
  assign phase_d       = next_of(phase_q);
  assign early_ok      = ext_edge & (phase_q == HW_PASS) & (remain_q > 8'd1);
  assign ext_ok        = ext_edge & (phase_q == CR_PASS) & (ext_cnt_q < D_EXT_MAX);
  // An extension landing on a non-terminal tick adds to the already-decremented count.
  assign remain_base_d = tick ? (remain_q - 8'd1) : remain_q;
  assign remain_ext_d  = sat_add(remain_base_d, D_STEP);

`ifdef PED_REQ_EN
  logic ped_prev_q;
  logic ped_used_q;

  assign ped_apply = tp.ped_req & ~ped_prev_q & (phase_q == HW_PASS)
                   & (remain_q > T_PED_SHORT) & ~ped_used_q & ~terminal & ~early_ok;

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      ped_prev_q <= 1'b0;
      ped_used_q <= 1'b0;
    end else begin
      ped_prev_q <= tp.ped_req;
      if (phase_q != HW_PASS) begin
        ped_used_q <= 1'b0;
      end else if (ped_apply) begin
        ped_used_q <= 1'b1;
      end
    end
  end
`else
  assign ped_apply = 1'b0;
`endif

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      phase_q     <= CR_PASS;
      remain_q    <= D_CR_PASS;
      led_q       <= LED_CR_PASS;
      phase_end_q <= 1'b0;
      ext_cnt_q   <= 3'd0;
      ext_prev_q  <= 1'b0;
    end else begin
      ext_prev_q  <= tp.ext_req;
      phase_end_q <= 1'b0;
      if (terminal) begin
        phase_q     <= phase_d;
        remain_q    <= dur_of(phase_d);
        led_q       <= led_of(phase_d);
        phase_end_q <= 1'b1;
        if (phase_d == CR_PASS) begin
          ext_cnt_q <= 3'd0;
        end
      end else if (early_ok) begin
        phase_q     <= HW_WARN;
        remain_q    <= D_HW_WARN;
        led_q       <= LED_HW_WARN;
        phase_end_q <= 1'b1;
      end else if (ext_ok) begin
        remain_q  <= remain_ext_d;
        ext_cnt_q <= ext_cnt_q + 3'd1;
      end else if (ped_apply) begin
        remain_q <= T_PED_SHORT;
      end else begin
        remain_q <= remain_base_d;
      end
    end
  end

  assign tp.phase     = phase_q;
  assign tp.remain    = remain_q;
  assign tp.LED       = led_q;
  assign tp.phase_end = phase_end_q;
  assign tp.ext_cnt   = ext_cnt_q;

endmodule
